// File: rtl/alu_operand_fetch_if.sv
// Bundle of the operand-fetch stage signals: instruction handshake, register-file read port,
// flags, writeback snoop and the issued ALU operand bundle.
interface alu_operand_fetch_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned REG_AW = 3
);
   logic [15:0]       instr;
   logic              instr_valid;
   logic              instr_ready;
   logic [REG_AW-1:0] rf_addr_a;
   logic [REG_AW-1:0] rf_addr_b;
   logic [DATA_W-1:0] rf_data_a;
   logic [DATA_W-1:0] rf_data_b;
   logic              carry_flag;
   logic              zero_flag;
   logic              wb_en;
   logic [REG_AW-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [1:0]        alu_op_sel;
   logic              alu_aorb;
   logic [REG_AW-1:0] out_dest;
   logic              out_dest_we;
   logic [3:0]        out_opcode;
   logic              out_valid;
   logic              out_ready;
   logic              out_skip;
   logic              out_illegal;

   // Environment side: supplies instructions, register data, flags and downstream ready.
   modport master (
      output instr, instr_valid, rf_data_a, rf_data_b, carry_flag, zero_flag,
             wb_en, wb_addr, wb_data, out_ready,
      input  instr_ready, rf_addr_a, rf_addr_b, alu_a, alu_b, alu_op_sel, alu_aorb,
             out_dest, out_dest_we, out_opcode, out_valid, out_skip, out_illegal
   );

   // Stage side.
   modport slave (
      input  instr, instr_valid, rf_data_a, rf_data_b, carry_flag, zero_flag,
             wb_en, wb_addr, wb_data, out_ready,
      output instr_ready, rf_addr_a, rf_addr_b, alu_a, alu_b, alu_op_sel, alu_aorb,
             out_dest, out_dest_we, out_opcode, out_valid, out_skip, out_illegal
   );
endinterface

// File: rtl/alu_operand_fetch.sv
// Operand fetch for the 16-bit IITB-RISC ALU: IDLE -> ADDR -> CAP -> ISSUE, one instruction in flight.
// Optional macro FORWARD_EN bypasses a matching writeback into the operands during CAP.
module alu_operand_fetch #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned REG_AW = 3
) (
   input logic                clk,
   input logic                rst,
   alu_operand_fetch_if.slave bus
);

   localparam logic [3:0] OpAdd = 4'b0000;
   localparam logic [3:0] OpAdi = 4'b0001;
   localparam logic [3:0] OpNdu = 4'b0010;
   localparam logic [3:0] OpLhi = 4'b0011;
   localparam logic [3:0] OpLw  = 4'b0100;
   localparam logic [3:0] OpSw  = 4'b0101;
   localparam logic [3:0] OpBeq = 4'b1100;

   typedef enum logic [1:0] {StIdle, StAddr, StCap, StIssue} state_e;

   state_e            state_q, state_d;
   logic [15:0]       instr_q, instr_d;
   logic [REG_AW-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [1:0]        op_q, op_d;
   logic              aorb_q, aorb_d;
   logic [REG_AW-1:0] dest_q, dest_d;
   logic              we_q, we_d;
   logic [3:0]        opc_q, opc_d;
   logic              skip_p, illegal_p;

   logic [3:0]        opcode;
   logic [1:0]        cz;
   logic [DATA_W-1:0] sext6, lhi_val, src_a, src_b;
   logic              illegal, cond_ok;
   logic [DATA_W-1:0] bnd_a, bnd_b;
   logic [1:0]        bnd_op;
   logic              bnd_aorb, bnd_we;
   logic [REG_AW-1:0] bnd_dest;

   assign opcode  = instr_q[15:12];
   assign cz      = instr_q[1:0];
   assign sext6   = {{(DATA_W-6){instr_q[5]}}, instr_q[5:0]};
   assign lhi_val = {instr_q[8:0], {(DATA_W-9){1'b0}}};

`ifdef FORWARD_EN
   // A writeback landing in the CAP cycle is newer than what the register file returned.
   assign src_a = (bus.wb_en && bus.wb_addr == addr_a_q) ? bus.wb_data : bus.rf_data_a;
   assign src_b = (bus.wb_en && bus.wb_addr == addr_b_q) ? bus.wb_data : bus.rf_data_b;
`else
   logic unused_wb;
   assign unused_wb = ^{bus.wb_en, bus.wb_addr, bus.wb_data};
   assign src_a     = bus.rf_data_a;
   assign src_b     = bus.rf_data_b;
`endif

   always_comb begin
      illegal = 1'b0;
      case (opcode)
         OpAdd, OpNdu:                    illegal = (cz == 2'b11);
         OpAdi, OpLhi, OpLw, OpSw, OpBeq: illegal = 1'b0;
         default:                         illegal = 1'b1;
      endcase
   end

   // Conditional forms only exist on the register-register arithmetic/logic opcodes.
   always_comb begin
      cond_ok = 1'b1;
      if (opcode == OpAdd || opcode == OpNdu) begin
         if (cz == 2'b10) begin
            cond_ok = bus.carry_flag;
         end else if (cz == 2'b01) begin
            cond_ok = bus.zero_flag;
         end
      end
   end

   always_comb begin
      bnd_a    = src_a;
      bnd_b    = src_b;
      bnd_op   = 2'b00;
      bnd_aorb = 1'b0;
      bnd_dest = instr_q[5:3];
      bnd_we   = 1'b1;
      case (opcode)
         OpAdd: ;
         OpNdu: bnd_op = 2'b10;
         OpAdi: begin
            bnd_b    = sext6;
            bnd_dest = instr_q[8:6];
         end
         OpLhi: begin
            bnd_a    = lhi_val;
            bnd_b    = '0;
            bnd_op   = 2'b11;
            bnd_aorb = 1'b1;
            bnd_dest = instr_q[11:9];
         end
         OpLw: begin
            bnd_a    = sext6;
            bnd_dest = instr_q[11:9];
         end
         OpSw: begin
            bnd_a    = sext6;
            bnd_dest = instr_q[11:9];
            bnd_we   = 1'b0;
         end
         OpBeq: begin
            bnd_op   = 2'b01;
            bnd_dest = '0;
            bnd_we   = 1'b0;
         end
         default: bnd_we = 1'b0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      addr_a_d  = addr_a_q;
      addr_b_d  = addr_b_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      aorb_d    = aorb_q;
      dest_d    = dest_q;
      we_d      = we_q;
      opc_d     = opc_q;
      skip_p    = 1'b0;
      illegal_p = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.instr_valid) begin
               instr_d  = bus.instr;
               addr_a_d = bus.instr[11:9];
               addr_b_d = bus.instr[8:6];
               state_d  = StAddr;
            end
         end
         StAddr: begin
            if (illegal) begin
               illegal_p = 1'b1;
               state_d   = StIdle;
            end else begin
               state_d = StCap;
            end
         end
         StCap: begin
            if (!cond_ok) begin
               skip_p  = 1'b1;
               state_d = StIdle;
            end else begin
               a_d     = bnd_a;
               b_d     = bnd_b;
               op_d    = bnd_op;
               aorb_d  = bnd_aorb;
               dest_d  = bnd_dest;
               we_d    = bnd_we;
               opc_d   = opcode;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (bus.out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         instr_q  <= '0;
         addr_a_q <= '0;
         addr_b_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         aorb_q   <= 1'b0;
         dest_q   <= '0;
         we_q     <= 1'b0;
         opc_q    <= '0;
      end else begin
         state_q  <= state_d;
         instr_q  <= instr_d;
         addr_a_q <= addr_a_d;
         addr_b_q <= addr_b_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         aorb_q   <= aorb_d;
         dest_q   <= dest_d;
         we_q     <= we_d;
         opc_q    <= opc_d;
      end
   end

   // Outputs are forced low while rst is held, before the reset edge has cleared the state.
   always_comb begin
      bus.instr_ready = 1'b0;
      bus.rf_addr_a   = '0;
      bus.rf_addr_b   = '0;
      bus.alu_a       = '0;
      bus.alu_b       = '0;
      bus.alu_op_sel  = '0;
      bus.alu_aorb    = 1'b0;
      bus.out_dest    = '0;
      bus.out_dest_we = 1'b0;
      bus.out_opcode  = '0;
      bus.out_valid   = 1'b0;
      bus.out_skip    = 1'b0;
      bus.out_illegal = 1'b0;
      if (!rst) begin
         bus.instr_ready = (state_q == StIdle);
         bus.rf_addr_a   = addr_a_q;
         bus.rf_addr_b   = addr_b_q;
         bus.alu_a       = a_q;
         bus.alu_b       = b_q;
         bus.alu_op_sel  = op_q;
         bus.alu_aorb    = aorb_q;
         bus.out_dest    = dest_q;
         bus.out_dest_we = we_q;
         bus.out_opcode  = opc_q;
         bus.out_valid   = (state_q == StIssue);
         bus.out_skip    = skip_p;
         bus.out_illegal = illegal_p;
      end
   end

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Self-checking bench for alu_operand_fetch: directed cases plus randomized instructions,
// all checked by a transaction-level model of the stage.
module tb_alu_operand_fetch;

   typedef struct packed {
      logic        skip;
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  op;
      logic        aorb;
      logic [2:0]  dest;
      logic        we;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        rand_mode;
   logic [15:0] rf_mem [8];
   int          total = 0;
   int          bad   = 0;

   alu_operand_fetch_if bus ();

   alu_operand_fetch dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   assign bus.rf_data_a = rf_mem[bus.rf_addr_a];
   assign bus.rf_data_b = rf_mem[bus.rf_addr_b];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic is_illegal(input logic [15:0] ins);
      case (ins[15:12])
         4'h0, 4'h2:                   return ins[1:0] == 2'b11;
         4'h1, 4'h3, 4'h4, 4'h5, 4'hC: return 1'b0;
         default:                      return 1'b1;
      endcase
   endfunction

   function automatic exp_t model(input logic [15:0] ins, input logic [15:0] ra_v,
                                  input logic [15:0] rb_v, input logic c, input logic z);
      exp_t        e;
      logic [15:0] s6;
      s6 = {{10{ins[5]}}, ins[5:0]};
      e  = '0;
      e.we = 1'b1;
      case (ins[15:12])
         4'h0, 4'h2: begin
            e.a    = ra_v;
            e.b    = rb_v;
            e.op   = (ins[15:12] == 4'h2) ? 2'b10 : 2'b00;
            e.dest = ins[5:3];
            if (ins[1:0] == 2'b10) e.skip = !c;
            else if (ins[1:0] == 2'b01) e.skip = !z;
         end
         4'h1: begin
            e.a    = ra_v;
            e.b    = s6;
            e.dest = ins[8:6];
         end
         4'h3: begin
            e.a    = 16'(ins[8:0]) << 7;
            e.op   = 2'b11;
            e.aorb = 1'b1;
            e.dest = ins[11:9];
         end
         4'h4, 4'h5: begin
            e.a    = s6;
            e.b    = rb_v;
            e.dest = ins[11:9];
            e.we   = (ins[15:12] == 4'h4);
         end
         default: begin
            e.a  = ra_v;
            e.b  = rb_v;
            e.op = 2'b01;
            e.we = 1'b0;
         end
      endcase
      return e;
   endfunction

   function automatic logic [63:0] all_outputs();
      return {11'b0, bus.instr_ready, bus.out_valid, bus.out_skip, bus.out_illegal,
              bus.rf_addr_a, bus.rf_addr_b, bus.alu_a, bus.alu_b, bus.alu_op_sel,
              bus.alu_aorb, bus.out_dest, bus.out_dest_we, bus.out_opcode};
   endfunction

   // Per-cycle compare against the model; n counts cycles since the instruction was accepted.
   initial begin : compare
      int          n;
      logic [15:0] cur, ra_v, rb_v;
      exp_t        e;
      logic        prev_rst;
      n        = 0;
      cur      = '0;
      e        = '0;
      prev_rst = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("reset_outputs", all_outputs(), 64'd0);
            n = 0;
         end else begin
            if (prev_rst) begin
               chk("post_reset_regs", all_outputs() & ~(64'h1 << 52), 64'd0);
            end
            case (n)
               0: begin
                  chk("idle_ctl", {bus.instr_ready, bus.out_valid, bus.out_skip, bus.out_illegal},
                      4'b1000);
                  if (bus.instr_valid) begin
                     cur = bus.instr;
                     n   = 1;
                  end
               end
               1: begin
                  chk("addr_ctl", {bus.instr_ready, bus.out_valid, bus.out_skip, bus.out_illegal},
                      {3'b000, is_illegal(cur)});
                  chk("rf_addr", {bus.rf_addr_a, bus.rf_addr_b}, {cur[11:9], cur[8:6]});
                  n = is_illegal(cur) ? 0 : 2;
               end
               2: begin
`ifdef FORWARD_EN
                  ra_v = (bus.wb_en && bus.wb_addr == cur[11:9]) ? bus.wb_data : rf_mem[cur[11:9]];
                  rb_v = (bus.wb_en && bus.wb_addr == cur[8:6]) ? bus.wb_data : rf_mem[cur[8:6]];
`else
                  ra_v = rf_mem[cur[11:9]];
                  rb_v = rf_mem[cur[8:6]];
`endif
                  e = model(cur, ra_v, rb_v, bus.carry_flag, bus.zero_flag);
                  chk("cap_ctl", {bus.instr_ready, bus.out_valid, bus.out_skip, bus.out_illegal},
                      {2'b00, e.skip, 1'b0});
                  n = e.skip ? 0 : 3;
               end
               default: begin
                  chk("issue_ctl", {bus.instr_ready, bus.out_valid, bus.out_skip, bus.out_illegal},
                      4'b0100);
                  chk("bundle", {bus.alu_a, bus.alu_b, bus.alu_op_sel, bus.alu_aorb,
                                 bus.out_dest_we, bus.out_opcode},
                      {e.a, e.b, e.op, e.aorb, e.we, cur[15:12]});
                  if (cur[15:12] != 4'hC) chk("dest", bus.out_dest, e.dest);
                  if (bus.out_ready) n = 0;
               end
            endcase
         end
         prev_rst = rst;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_mode) begin
         bus.carry_flag = 1'($urandom);
         bus.zero_flag  = 1'($urandom);
         bus.wb_en      = 1'($urandom);
         bus.wb_addr    = 3'($urandom);
         bus.wb_data    = 16'($urandom);
         bus.out_ready  = ($urandom_range(0, 3) != 0);
      end
   endtask

   // Busy cycles carry junk on instr/instr_valid that the stage must ignore.
   task automatic wait_idle();
      int guard;
      guard = 0;
      while (!bus.instr_ready && guard < 100) begin
         tick();
         guard++;
         if (rand_mode) begin
            bus.instr_valid = 1'($urandom);
            bus.instr       = 16'($urandom);
         end
      end
      bus.instr_valid = 1'b0;
      if (!bus.instr_ready) begin
         $display("FAIL wait_idle: instr_ready stuck at %0b want 1", bus.instr_ready);
         bad++;
         total++;
      end
   endtask

   task automatic send(input logic [15:0] ins);
      chk("send_ready", bus.instr_ready, 1'b1);
      bus.instr       = ins;
      bus.instr_valid = 1'b1;
      tick();
      bus.instr_valid = 1'b0;
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : driver
      logic [3:0] op;
      rst             = 1'b1;
      rand_mode       = 1'b0;
      bus.instr       = '0;
      bus.instr_valid = 1'b0;
      bus.carry_flag  = 1'b0;
      bus.zero_flag   = 1'b0;
      bus.wb_en       = 1'b0;
      bus.wb_addr     = '0;
      bus.wb_data     = '0;
      bus.out_ready   = 1'b1;
      for (int i = 0; i < 8; i++) rf_mem[i] = 16'(i * 16'h1111);
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // ADD R3 = R1 + R2, latency three edges from accept
      wait_idle();
      rf_mem[1] = 16'h0005;
      rf_mem[2] = 16'h0007;
      send(16'h0298);
      chk("add_valid_e1", bus.out_valid, 1'b0);
      tick();
      chk("add_valid_e2", bus.out_valid, 1'b0);
      tick();
      chk("add_valid_e3", bus.out_valid, 1'b1);
      chk("add_ab", {bus.alu_a, bus.alu_b}, {16'h0005, 16'h0007});
      chk("add_ctl", {bus.alu_op_sel, bus.out_dest, bus.out_dest_we}, {2'b00, 3'd3, 1'b1});

      // ADI R2 = R0 + sext(0x3F)
      wait_idle();
      rf_mem[0] = 16'h0010;
      send(16'h10BF);
      repeat (2) tick();
      chk("adi_valid", bus.out_valid, 1'b1);
      chk("adi_ab", {bus.alu_a, bus.alu_b}, {16'h0010, 16'hFFFF});
      chk("adi_ctl", {bus.alu_op_sel, bus.out_dest}, {2'b00, 3'd2});

      // ADC with carry clear is squashed, then with carry set it issues
      wait_idle();
      bus.carry_flag = 1'b0;
      send(16'h029A);
      tick();
      chk("adc_skip", {bus.out_skip, bus.out_valid}, 2'b10);
      tick();
      chk("adc_after_skip", {bus.instr_ready, bus.out_valid, bus.out_skip}, 3'b100);
      bus.carry_flag = 1'b1;
      send(16'h029A);
      tick();
      chk("adc_noskip", bus.out_skip, 1'b0);
      tick();
      chk("adc_issue", {bus.out_valid, bus.alu_a, bus.alu_b}, {1'b1, 16'h0005, 16'h0007});

      // LHI R4 with downstream stalled for five cycles
      wait_idle();
      bus.out_ready = 1'b0;
      send(16'h39FF);
      repeat (2) tick();
      chk("lhi_bundle", {bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_op_sel, bus.alu_aorb,
                         bus.out_dest}, {1'b1, 16'hFF80, 16'h0000, 2'b11, 1'b1, 3'd4});
      repeat (5) begin
         tick();
         chk("lhi_hold", {bus.out_valid, bus.alu_a}, {1'b1, 16'hFF80});
      end
      bus.out_ready = 1'b1;
      tick();
      chk("lhi_release", {bus.out_valid, bus.instr_ready}, 2'b01);

      // JAL is not supported here
      wait_idle();
      send(16'h8000);
      chk("jal_illegal", {bus.out_illegal, bus.out_valid}, 2'b10);
      tick();
      chk("jal_after", {bus.out_illegal, bus.instr_ready}, 2'b01);

      // Reset while a bundle is waiting
      wait_idle();
      bus.out_ready = 1'b0;
      send(16'h0298);
      repeat (2) tick();
      chk("rst_pre_valid", bus.out_valid, 1'b1);
      rst = 1'b1;
      tick();
      chk("rst_outputs", all_outputs(), 64'd0);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      chk("rst_after", {bus.instr_ready, bus.out_valid, bus.alu_a}, {1'b1, 1'b0, 16'h0000});

      // Writeback to R1 during CAP
      wait_idle();
      rf_mem[1]   = 16'h0001;
      bus.wb_en   = 1'b1;
      bus.wb_addr = 3'd1;
      bus.wb_data = 16'hABCD;
      send(16'h0298);
      repeat (2) tick();
`ifdef FORWARD_EN
      chk("fwd_a", {bus.out_valid, bus.alu_a}, {1'b1, 16'hABCD});
`else
      chk("fwd_a", {bus.out_valid, bus.alu_a}, {1'b1, 16'h0001});
`endif
      bus.wb_en = 1'b0;

      // Randomized instruction stream
      rand_mode = 1'b1;
      for (int k = 0; k < 400; k++) begin
         wait_idle();
         for (int i = 0; i < 8; i++) rf_mem[i] = 16'($urandom);
         case ($urandom_range(0, 9))
            0:       op = 4'h0;
            1:       op = 4'h1;
            2:       op = 4'h2;
            3:       op = 4'h3;
            4:       op = 4'h4;
            5:       op = 4'h5;
            6:       op = 4'hC;
            default: op = 4'($urandom);
         endcase
         send({op, 12'($urandom)});
         if ($urandom_range(0, 3) == 0) tick();
      end
      rand_mode     = 1'b0;
      bus.out_ready = 1'b1;
      wait_idle();
      repeat (2) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_operand_fetch.md
Name: alu_operand_fetch

Overview:
Upstream stage of the 16-bit ALU (op_sel/aorb/A/B interface). It accepts one decoded IITB-RISC instruction word and reads the two source registers from a synchronous-read register file. It builds the ALU operands, immediates and control, evaluates the ADC/ADZ/NDC/NDZ carry/zero conditions, and presents one operand bundle per instruction under a valid/ready handshake.

Parameters:
DATA_W, 16, operand width (fixed to the ALU width; other values unsupported)
REG_AW, 3, register-file address width (8 registers)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
instr  in  16  instruction word: [15:12] opcode, [11:9] RA, [8:6] RB, [5:3] RC, [1:0] cz, [5:0] imm6, [8:0] imm9
instr_valid  in  1  instr presented
instr_ready  out  1  stage can accept; high only in IDLE and not in reset
rf_addr_a  out  REG_AW  register-file read address A (registered)
rf_addr_b  out  REG_AW  register-file read address B (registered)
rf_data_a  in  DATA_W  read data A, valid one cycle after address
rf_data_b  in  DATA_W  read data B, valid one cycle after address
carry_flag  in  1  architectural carry
zero_flag  in  1  architectural zero
wb_en  in  1  writeback strobe (used only with FORWARD_EN)
wb_addr  in  REG_AW  writeback register
wb_data  in  DATA_W  writeback data
alu_a  out  DATA_W  operand A to ALU
alu_b  out  DATA_W  operand B to ALU
alu_op_sel  out  2  00 add, 01 equality, 10 nand, 11 pass
alu_aorb  out  1  pass select (1 = A)
out_dest  out  REG_AW  destination register
out_dest_we  out  1  destination is written
out_opcode  out  4  opcode passthrough
out_valid  out  1  bundle valid
out_ready  in  1  downstream accepts
out_skip  out  1  one-cycle pulse: condition false, instruction squashed
out_illegal  out  1  one-cycle pulse: unsupported opcode or cz=11

Behaviour:
- Reset: state IDLE. All outputs 0, including instr_ready during reset. instr_ready is 1 from the first cycle after rst deasserts. rst mid-operation aborts the instruction with no pulse and no issue.
- FSM IDLE -> ADDR -> CAP -> ISSUE -> IDLE.
- IDLE: when instr_valid & instr_ready, latch instr and register rf_addr_a=RA, rf_addr_b=RB; go to ADDR.
- ADDR: the register file samples the addresses. Decode the instruction. If illegal, pulse out_illegal for this cycle and go to IDLE; otherwise go to CAP.
- CAP: rf_data is valid. Evaluate the condition:
  - cz=10 requires carry_flag=1.
  - cz=01 requires zero_flag=1.
  - The check applies to opcodes 0000 and 0010 only.
  - If false, pulse out_skip for this cycle and go to IDLE.
  - Otherwise register the full bundle and go to ISSUE.
- ISSUE: out_valid=1 and the bundle is held stable until out_ready. On out_valid & out_ready, go to IDLE and clear out_valid on that edge.
- Latency and throughput: out_valid rises after the 3rd rising edge, counting the accept edge as the 1st. At most one instruction is in flight. A new accept cannot occur in the same cycle as an ISSUE handshake.
- sext(imm6) sign-extends bit 5 to 16 bits.
- Decode:
  - 0000 ADD/ADC/ADZ: A=R[RA], B=R[RB], op 00, dest RC, we 1.
  - 0010 NDU/NDC/NDZ: as ADD, op 10.
  - 0001 ADI: A=R[RA], B=sext(imm6), op 00, dest RB, we 1.
  - 0011 LHI: A={imm9,7'b0}, B=0, op 11, aorb 1, dest RA, we 1.
  - 0100 LW: A=sext(imm6), B=R[RB], op 00, dest RA, we 1.
  - 0101 SW: as LW, we 0.
  - 1100 BEQ: A=R[RA], B=R[RB], op 01, we 0.
  - All other opcodes, and cz=11 on 0000/0010, are illegal.
- alu_aorb is 0 except for LHI. out_opcode is the latched opcode.
- Flags are sampled in CAP only; later flag changes do not affect an issued bundle.
- The out_skip and out_illegal pulses are mutually exclusive, and out_valid is never asserted for a skipped or illegal instruction.

Optional Feature:
FORWARD_EN defined:
- In CAP, if wb_en=1 and wb_addr equals a source register used by the instruction, that operand takes wb_data instead of rf_data.
- A/B are checked independently; RA==RB with a match forwards both.

FORWARD_EN undefined:
- The wb_* ports are ignored and operands come only from rf_data.

Test Plan:
- ADD R3=R1+R2 (instr 0x0298), rf_data_a=0x0005, rf_data_b=0x0007, out_ready=1: out_valid 3 edges after accept. Bundle: alu_a=5, alu_b=7, op 00, out_dest=3, out_dest_we=1.
- ADI RB=2, imm6=0x3F (instr 0x10BF), rf_data_a=0x0010: alu_b=0xFFFF, op 00, out_dest=2.
- ADC (cz=10) with carry_flag=0: out_skip one cycle in CAP, no out_valid, instr_ready high next cycle. Repeat with carry_flag=1: issues normally.
- LHI RA=4, imm9=0x1FF (instr 0x39FF): alu_a=0xFF80, alu_b=0, op 11, aorb 1. Hold out_ready=0 for 5 cycles: bundle stable; handshake then returns the stage to IDLE.
- Opcode 0x8 (JAL): out_illegal pulse in ADDR, no out_valid. Separately, assert rst during ISSUE: next cycle out_valid=0 and all outputs 0.
- FORWARD_EN: ADD with RA=1, wb_en=1, wb_addr=1, wb_data=0xABCD in CAP, rf_data_a=0x0001: alu_a=0xABCD. Without the macro: alu_a=0x0001.
